fifo_credit_vc: RTL and testbench
=================================

// Module: fifo_credit_vc
// PURPOSE
//  Multi-channel (virtual-channel) credit FIFO; successor to the single-channel credit FIFO.
//  NUM_CH independent queues of DEPTH entries share one storage array. Each has its own credit counter and credit-return pulse.
//  Sits between a credit-based producer (one write port, channel-tagged) and a single consumer.
//  Consumer is served by a round-robin arbiter with a grant lock on stall.
// PARAMETERS
//  DATA_WIDTH  32  payload width in bits
//  DEPTH       8   entries per channel; power of 2, >=2
//  NUM_CH      4   number of channels; >=2
//  (local) ADDR_W=$clog2(DEPTH), CH_W=$clog2(NUM_CH), CNT_W=ADDR_W+1
// PORTS
//  clk            in   1                  clock; all logic on posedge
//  rst            in   1                  reset, asynchronous, active-high
//  wr_valid       in   1                  write request
//  wr_ch          in   CH_W               target channel of write
//  wr_data        in   DATA_WIDTH         write payload
//  wr_ready       out  1                  credit_count[wr_ch] != 0 (combinational on wr_ch)
//  rd_valid       out  1                  a channel is presented to consumer
//  rd_ch          out  CH_W               channel of presented word
//  rd_data        out  DATA_WIDTH         head word of rd_ch (show-ahead)
//  rd_ready       in   1                  consumer accept
//  credit_count   out  NUM_CH*CNT_W       packed per-channel free entries; ch c at [c*CNT_W +: CNT_W]
//  credit_return  out  NUM_CH             1-cycle pulse per channel, registered, one cycle after a pop on that channel
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - all wr/rd ptrs and fifo counts 0; every credit_count = DEPTH
//   - credit_return 0, lock 0, last_grant = NUM_CH-1 (ch0 has first priority)
//   - rd_valid 0; storage not reset
//  Write: do_wr = wr_valid & wr_ready.
//   - Stores at mem[{wr_ch,wr_ptr[wr_ch]}]; wr_ptr wraps mod DEPTH.
//   - wr_valid while wr_ready=0 is ignored (no state change).
//  Read: rd_valid = lock | (any fifo_count != 0); do_rd = rd_valid & rd_ready.
//   - Pops rd_ch; rd_ptr wraps mod DEPTH.
//   - credit_return[rd_ch] = 1 next cycle.
//  Arbitration: when unlocked, rd_ch = first nonempty channel searching from last_grant+1 upward, wrapping.
//   - last_grant <= rd_ch on do_rd only.
//  Grant lock: rd_valid & !rd_ready sets lock and holds rd_ch.
//   - rd_ch/rd_data stay stable until accept, even if other channels fill.
//   - lock clears on do_rd.
//  Counters, per channel c:
//   - push only: count+1, credit-1
//   - pop only: count-1, credit+1
//   - push & pop same channel in one cycle: both unchanged, both ptrs advance
//   - push c and pop d (c != d): each updates independently
//  Full: credit 0 -> wr_ready=0 for that channel only.
//   - A pop on a full channel restores its credit next cycle; no same-cycle bypass into full.
//  Empty: channel never granted.
//   - A push into an empty channel is visible to the arbiter from the next cycle (no write-through).
//  Invariant: count[c]+credit[c]==DEPTH always; SVA assertion required.
//  Latency: write-to-rd_valid 1 cycle min; pop-to-credit_return 1 cycle; pop-to-credit_count 1 cycle.
// STRUCTURE
//  Package fifo_credit_pkg: ch_t, cnt_t typedefs (parametrised via macros/localparams).
//  Sub-module rr_arbiter #(N): inputs req[N], last_grant; outputs gnt_idx, gnt_any.
//   - Purely combinational.
//   - Lock/last_grant registers live in fifo_credit_vc.
//  Storage: single array mem[NUM_CH*DEPTH], addressed {ch,ptr}.
// TESTING
//  T1 reset:
//   - assert rst mid-cycle -> immediately rd_valid=0, all credits=8, credit_return=0.
//   - after release, wr_ready=1 for every wr_ch.
//  T2 fill ch2 with 0x100..0x107:
//   - credit ch2=0; wr_ready=0 for wr_ch=2, 1 for wr_ch=0.
//   - 9th write ignored; drain returns 0x100..0x107 in order, rd_ch=2.
//  T3 RR: one word each in ch0,ch1,ch3, rd_ready=1:
//   - pops in order ch0,ch1,ch3 on consecutive cycles.
//   - credit_return = 4'b0001, 4'b0010, 4'b1000 each one cycle later.
//  T4 lock: ch1 presented, rd_ready=0 for 3 cycles while writing ch0:
//   - rd_ch=1 and rd_data stable; ch0 served after ch1 accepted.
//  T5 simultaneous: ch0 count=3, push+pop ch0 same cycle:
//   - credit ch0 stays 5; credit_return[0] pulses.
//   - full ch3 + pop ch3 with wr_ch=3: write refused that cycle, credit 1 next cycle.
//  T6 wrap: 20 push/pop pairs on ch1 (ptr wraps twice) -> data in order, invariant holds throughout.

Source files
------------

// File: rtl/fifo_credit_vc_pkg.sv
// Shared types and helpers for the multi-channel credit FIFO.
// Typedefs follow the default build (4 channels of 8 entries).
package fifo_credit_vc_pkg;

    localparam int DEF_DEPTH  = 8;
    localparam int DEF_NUM_CH = 4;
    localparam int DEF_CH_W   = $clog2(DEF_NUM_CH);
    localparam int DEF_CNT_W  = $clog2(DEF_DEPTH) + 1;

    typedef logic [DEF_CH_W-1:0]  ch_t;
    typedef logic [DEF_CNT_W-1:0] cnt_t;

    // Channel index reached by stepping 'off' positions past 'last', wrapping at n.
    function automatic int rr_next(input int last, input int off, input int n);
        return (last + off) % n;
    endfunction

endpackage

// File: rtl/fifo_credit_vc_arb.sv
// Combinational round-robin arbiter: picks the first requester after last_grant.
// Lock and last-grant state are held by the caller.
module rr_arbiter
    import fifo_credit_vc_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last_grant,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 gnt_any
);

    localparam int W = $clog2(N);

    logic [W-1:0] w_idx;

    // Scan from the farthest candidate down so the nearest requester wins.
    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        w_idx   = '0;
        for (int i = N; i >= 1; i--) begin
            w_idx = W'(rr_next(int'(last_grant), i, N));
            if (req[w_idx]) begin
                gnt_idx = w_idx;
                gnt_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_credit_vc.sv
// Virtual-channel credit FIFO: NUM_CH queues sharing one storage array,
// per-channel credits, round-robin read arbitration with grant lock on stall.
module fifo_credit_vc
    import fifo_credit_vc_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int NUM_CH     = 4
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     wr_valid,
    input  logic [$clog2(NUM_CH)-1:0]                wr_ch,
    input  logic [DATA_WIDTH-1:0]                    wr_data,
    output logic                                     wr_ready,
    output logic                                     rd_valid,
    output logic [$clog2(NUM_CH)-1:0]                rd_ch,
    output logic [DATA_WIDTH-1:0]                    rd_data,
    input  logic                                     rd_ready,
    output logic [NUM_CH*($clog2(DEPTH)+1)-1:0]      credit_count,
    output logic [NUM_CH-1:0]                        credit_return
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CH_W   = $clog2(NUM_CH);
    localparam int CNT_W  = ADDR_W + 1;

    logic [DATA_WIDTH-1:0] r_mem [NUM_CH*DEPTH];
    logic [ADDR_W-1:0]     r_wr_ptr [NUM_CH];
    logic [ADDR_W-1:0]     r_rd_ptr [NUM_CH];
    logic [CNT_W-1:0]      r_count  [NUM_CH];
    logic [CNT_W-1:0]      r_credit [NUM_CH];
    logic                  r_lock;
    logic [CH_W-1:0]       r_lock_ch;
    logic [CH_W-1:0]       r_last_grant;
    logic [NUM_CH-1:0]     r_credit_return;

    logic [NUM_CH-1:0]     w_req;
    logic [NUM_CH-1:0]     w_push;
    logic [NUM_CH-1:0]     w_pop;
    logic [CH_W-1:0]       w_gnt_idx;
    logic                  w_gnt_any;
    logic                  w_do_wr;
    logic                  w_do_rd;

    always_comb begin
        w_req        = '0;
        w_push       = '0;
        w_pop        = '0;
        credit_count = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_req[c]                         = (r_count[c] != '0);
            w_push[c]                        = w_do_wr && (wr_ch == CH_W'(c));
            w_pop[c]                         = w_do_rd && (rd_ch == CH_W'(c));
            credit_count[c*CNT_W +: CNT_W]   = r_credit[c];
        end
    end

    rr_arbiter #(
        .N(NUM_CH)
    ) u_arb (
        .req        (w_req),
        .last_grant (r_last_grant),
        .gnt_idx    (w_gnt_idx),
        .gnt_any    (w_gnt_any)
    );

    // A stalled grant stays locked so the consumer sees a stable word.
    assign rd_valid      = r_lock | w_gnt_any;
    assign rd_ch         = r_lock ? r_lock_ch : w_gnt_idx;
    assign rd_data       = r_mem[{rd_ch, r_rd_ptr[rd_ch]}];
    assign wr_ready      = (r_credit[wr_ch] != '0);
    assign w_do_wr       = wr_valid & wr_ready;
    assign w_do_rd       = rd_valid & rd_ready;
    assign credit_return = r_credit_return;

    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[{wr_ch, r_wr_ptr[wr_ch]}] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_wr_ptr[c] <= '0;
                r_rd_ptr[c] <= '0;
                r_count[c]  <= '0;
                r_credit[c] <= CNT_W'(DEPTH);
            end
            r_lock          <= 1'b0;
            r_lock_ch       <= '0;
            r_last_grant    <= CH_W'(NUM_CH - 1);
            r_credit_return <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_push[c]) begin
                    r_wr_ptr[c] <= r_wr_ptr[c] + ADDR_W'(1);
                end
                if (w_pop[c]) begin
                    r_rd_ptr[c] <= r_rd_ptr[c] + ADDR_W'(1);
                end
                if (w_push[c] && !w_pop[c]) begin
                    r_count[c]  <= r_count[c] + CNT_W'(1);
                    r_credit[c] <= r_credit[c] - CNT_W'(1);
                end else if (w_pop[c] && !w_push[c]) begin
                    r_count[c]  <= r_count[c] - CNT_W'(1);
                    r_credit[c] <= r_credit[c] + CNT_W'(1);
                end
            end
            r_credit_return <= w_pop;
            if (w_do_rd) begin
                r_lock       <= 1'b0;
                r_last_grant <= rd_ch;
            end else if (rd_valid) begin
                r_lock    <= 1'b1;
                r_lock_ch <= rd_ch;
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_inv
        a_credit_inv: assert property (@(posedge clk) disable iff (rst)
            ({1'b0, r_count[c]} + {1'b0, r_credit[c]}) == (CNT_W+1)'(DEPTH));
    end

endmodule

// File: tb/tb_fifo_credit_vc.sv
// Directed bench for fifo_credit_vc with a per-channel data scoreboard
// and an independent round-robin / lock reference model.
module tb_fifo_credit_vc;

    localparam int DW     = 32;
    localparam int DEPTH  = 8;
    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;
    localparam int CNT_W  = 4;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    wr_valid;
    logic [CH_W-1:0]         wr_ch;
    logic [DW-1:0]           wr_data;
    logic                    wr_ready;
    logic                    rd_valid;
    logic [CH_W-1:0]         rd_ch;
    logic [DW-1:0]           rd_data;
    logic                    rd_ready;
    logic [NUM_CH*CNT_W-1:0] credit_count;
    logic [NUM_CH-1:0]       credit_return;

    fifo_credit_vc #(
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH),
        .NUM_CH    (NUM_CH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_valid     (wr_valid),
        .wr_ch        (wr_ch),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .rd_valid     (rd_valid),
        .rd_ch        (rd_ch),
        .rd_data      (rd_data),
        .rd_ready     (rd_ready),
        .credit_count (credit_count),
        .credit_return(credit_return)
    );

    always #5 clk = ~clk;

    int                n_total = 0;
    int                n_pass  = 0;
    int                n_fail  = 0;
    logic [DW-1:0]     exp_q [NUM_CH][$];
    int                ord_q [$];
    logic              m_lock;
    int                m_lock_ch;
    int                m_last;
    logic [NUM_CH-1:0] exp_cr;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_rdch();
        if (m_lock) return m_lock_ch;
        for (int i = 1; i <= NUM_CH; i++) begin
            int k;
            k = (m_last + i) % NUM_CH;
            if (exp_q[k].size() != 0) return k;
        end
        return 0;
    endfunction

    // Asserts reset just after a rising edge, checks the asynchronous effect, releases one cycle later.
    task automatic do_reset();
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        rst      = 1'b1;
        #2;
        check("rst_rd_valid", rd_valid, 0);
        check("rst_credit_return", credit_return, 0);
        for (int c = 0; c < NUM_CH; c++)
            check("rst_credit", credit_count[c*CNT_W +: CNT_W], DEPTH);
        for (int c = 0; c < NUM_CH; c++) exp_q[c].delete();
        ord_q.delete();
        m_lock    = 1'b0;
        m_lock_ch = 0;
        m_last    = NUM_CH - 1;
        exp_cr    = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // One clock: drive, check against the model at the falling edge, advance the model.
    task automatic cycle(input logic wv, input int wch, input logic [DW-1:0] wd, input logic rr);
        int   ech;
        logic any;
        logic wexp;
        wr_valid = wv;
        wr_ch    = CH_W'(wch);
        wr_data  = wd;
        rd_ready = rr;
        @(negedge clk);
        any = 1'b0;
        for (int c = 0; c < NUM_CH; c++)
            if (exp_q[c].size() != 0) any = 1'b1;
        ech = exp_rdch();
        check("rd_valid", rd_valid, any);
        if (any) begin
            check("rd_ch", rd_ch, ech);
            check("rd_data", rd_data, exp_q[ech][0]);
        end
        wexp = (exp_q[wch].size() < DEPTH);
        check("wr_ready", wr_ready, wexp);
        for (int c = 0; c < NUM_CH; c++)
            check("credit_count", credit_count[c*CNT_W +: CNT_W], DEPTH - exp_q[c].size());
        check("credit_return", credit_return, exp_cr);
        exp_cr = '0;
        if (any && rr) begin
            if (ord_q.size() > 0) begin
                int e;
                e = ord_q.pop_front();
                check("rr_order", rd_ch, e);
            end
            void'(exp_q[ech].pop_front());
            exp_cr = NUM_CH'(1 << ech);
            m_last = ech;
            m_lock = 1'b0;
        end else if (any) begin
            m_lock    = 1'b1;
            m_lock_ch = ech;
        end
        if (wv && wexp) exp_q[wch].push_back(wd);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        wr_valid = 1'b0;
        wr_ch    = '0;
        wr_data  = '0;
        rd_ready = 1'b0;
        @(posedge clk);
        #1;

        // T1: reset, then an asynchronous reset in the middle of activity
        do_reset();
        cycle(1'b1, 0, 32'h11, 1'b0);
        cycle(1'b0, 0, 32'h0, 1'b0);
        do_reset();
        for (int w = 0; w < NUM_CH; w++) begin
            wr_ch = CH_W'(w);
            #1;
            check("wr_ready_after_rst", wr_ready, 1);
        end
        @(posedge clk);
        #1;

        // T2: fill channel 2, refused 9th write, in-order drain
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 2, 32'h100 + i, 1'b0);
        check("ch2_full_credit", credit_count[2*CNT_W +: CNT_W], 0);
        wr_valid = 1'b0;
        wr_ch    = 2'd2;
        #1;
        check("ch2_full_wr_ready", wr_ready, 0);
        wr_ch = 2'd0;
        #1;
        check("ch0_free_wr_ready", wr_ready, 1);
        cycle(1'b1, 2, 32'h1FF, 1'b0);
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 0, 32'h0, 1'b1);
        cycle(1'b0, 0, 32'h0, 1'b0);

        // T3: round-robin across channels 0, 1, 3
        do_reset();
        cycle(1'b1, 0, 32'hC0, 1'b0);
        cycle(1'b1, 1, 32'hC1, 1'b0);
        cycle(1'b1, 3, 32'hC3, 1'b0);
        ord_q = '{0, 1, 3};
        for (int i = 0; i < 3; i++) cycle(1'b0, 0, 32'h0, 1'b1);
        cycle(1'b0, 0, 32'h0, 1'b0);
        check("rr_all_popped", ord_q.size(), 0);

        // T4: grant lock on channel 1 while channel 0 fills
        do_reset();
        cycle(1'b1, 1, 32'h1A1, 1'b0);
        cycle(1'b1, 0, 32'hA0, 1'b0);
        cycle(1'b1, 0, 32'hA1, 1'b0);
        cycle(1'b1, 0, 32'hA2, 1'b0);
        check("lock_rd_ch", rd_ch, 1);
        check("lock_rd_data", rd_data, 32'h1A1);
        ord_q = '{1, 0, 0, 0};
        for (int i = 0; i < 4; i++) cycle(1'b0, 0, 32'h0, 1'b1);
        cycle(1'b0, 0, 32'h0, 1'b0);

        // T5: push and pop on one channel; pop on a full channel
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 0, 32'h50 + i, 1'b0);
        cycle(1'b1, 0, 32'h53, 1'b1);
        check("push_pop_credit", credit_count[0 +: CNT_W], 5);
        check("push_pop_return", credit_return, 4'b0001);
        for (int i = 0; i < 3; i++) cycle(1'b0, 0, 32'h0, 1'b1);
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 3, 32'h300 + i, 1'b0);
        cycle(1'b1, 3, 32'h3FF, 1'b1);
        check("full_pop_credit", credit_count[3*CNT_W +: CNT_W], 1);
        for (int i = 0; i < DEPTH - 1; i++) cycle(1'b0, 0, 32'h0, 1'b1);
        cycle(1'b0, 0, 32'h0, 1'b0);

        // T6: pointer wrap with back-to-back push/pop pairs
        do_reset();
        cycle(1'b1, 1, 32'h600, 1'b0);
        for (int i = 1; i <= 20; i++) cycle(1'b1, 1, 32'h600 + i, 1'b1);
        cycle(1'b0, 0, 32'h0, 1'b1);
        cycle(1'b0, 0, 32'h0, 1'b0);
        check("wrap_empty", rd_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
